// File: rtl/multicycle_pkg.sv
// multicycle_pkg: opcodes, state/class encodings and datapath select codes for the multicycle controller
package multicycle_pkg;
  localparam logic [5:0] OP_NOOP = 6'b000000;
  localparam logic [5:0] OP_MOV  = 6'b010000;
  localparam logic [5:0] OP_ADD  = 6'b010010;
  localparam logic [5:0] OP_SUB  = 6'b010011;
  localparam logic [5:0] OP_OR   = 6'b010100;
  localparam logic [5:0] OP_AND  = 6'b010101;
  localparam logic [5:0] OP_ADDI = 6'b110010;
  localparam logic [5:0] OP_SUBI = 6'b110011;
  localparam logic [5:0] OP_ORI  = 6'b110100;
  localparam logic [5:0] OP_ANDI = 6'b110101;
  localparam logic [5:0] OP_BEQ  = 6'b100000;
  localparam logic [5:0] OP_LI   = 6'b111001;
  localparam logic [5:0] OP_LWI  = 6'b111011;
  localparam logic [5:0] OP_SWI  = 6'b111100;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_BRANCH, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {C_NOOP, C_ALUR, C_ALUI, C_BEQ, C_LWI, C_SWI, C_LI} cls_t;
  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_OR     = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_PASS_A = 3'd4;
  localparam logic [1:0] SA_PC    = 2'd0;
  localparam logic [1:0] SA_A     = 2'd1;
  localparam logic [1:0] SA_OLDPC = 2'd2;
  localparam logic [1:0] SB_B    = 2'd0;
  localparam logic [1:0] SB_ONE  = 2'd1;
  localparam logic [1:0] SB_SEXT = 2'd2;
  localparam logic [1:0] SB_ZEXT = 2'd3;
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_IMM = 2'd2;
endpackage

// File: rtl/multicycle_opdecode.sv
// multicycle_opdecode: maps an opcode to instruction class, ALU operation, immediate extension and legality
module multicycle_opdecode
  import multicycle_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] opcode,
  output logic [2:0]      cls,
  output logic [2:0]      alu_op,
  output logic            imm_zext,
  output logic            legal
);
  always_comb begin
    cls = C_NOOP;
    alu_op = ALU_ADD;
    imm_zext = 1'b0;
    legal = 1'b1;
    case (opcode)
      OP_NOOP: ;
      OP_MOV:  begin cls = C_ALUR; alu_op = ALU_PASS_A; end
      OP_ADD:  cls = C_ALUR;
      OP_SUB:  begin cls = C_ALUR; alu_op = ALU_SUB; end
      OP_OR:   begin cls = C_ALUR; alu_op = ALU_OR; end
      OP_AND:  begin cls = C_ALUR; alu_op = ALU_AND; end
      OP_ADDI: cls = C_ALUI;
      OP_SUBI: begin cls = C_ALUI; alu_op = ALU_SUB; end
      OP_ORI:  begin cls = C_ALUI; alu_op = ALU_OR; imm_zext = 1'b1; end
      OP_ANDI: begin cls = C_ALUI; alu_op = ALU_AND; imm_zext = 1'b1; end
      OP_BEQ:  cls = C_BEQ;
      OP_LI:   cls = C_LI;
      OP_LWI:  cls = C_LWI;
      OP_SWI:  cls = C_SWI;
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: start-gated FETCH/DECODE/EXEC/BRANCH/MEM/WB sequencer driving the datapath controls
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             old_pc_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);
  state_t state, nxt;
  logic [2:0] cls, dec_op;
  logic imm_zext, legal, done;
  multicycle_opdecode #(.OP_W(OP_W)) u_dec (
    .opcode  (opcode),
    .cls     (cls),
    .alu_op  (dec_op),
    .imm_zext(imm_zext),
    .legal   (legal)
  );
  always_comb begin
    done = state == S_BRANCH || state == S_WB || (state == S_MEM && cls == C_SWI) ||
           (state == S_DECODE && cls == C_NOOP);
    nxt = state == S_FETCH ? S_DECODE :
          (state == S_EXEC || state == S_MEM) ? S_WB :
          state != S_DECODE ? S_IDLE :
          cls == C_BEQ ? S_BRANCH :
          cls == C_LI ? S_WB :
          (cls == C_LWI || cls == C_SWI) ? S_MEM : S_EXEC;
    nxt = (done || state == S_IDLE) ? (start ? S_FETCH : S_IDLE) : nxt;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= S_IDLE;
      instr_count <= '0;
    end else begin
      state <= nxt;
      instr_count <= instr_count + CNT_W'(done);
    end
  always_comb begin
    ir_write = state == S_FETCH;
    old_pc_write = state == S_FETCH;
    pc_src = state == S_BRANCH && zero;
    pc_write = state == S_FETCH || (state == S_BRANCH && zero);
    alu_src_a = state == S_DECODE ? SA_OLDPC : (state == S_EXEC || state == S_BRANCH) ? SA_A : SA_PC;
    alu_src_b = state == S_FETCH ? SB_ONE :
                state == S_DECODE ? SB_SEXT :
                (state == S_EXEC && cls == C_ALUI) ? (imm_zext ? SB_ZEXT : SB_SEXT) : SB_B;
    alu_op = state == S_EXEC ? dec_op : state == S_BRANCH ? ALU_SUB : ALU_ADD;
    mem_read = state == S_MEM && cls == C_LWI;
    mem_write = state == S_MEM && cls == C_SWI;
    reg_write = state == S_WB;
    mem_to_reg = state != S_WB ? M2R_ALU : cls == C_LWI ? M2R_MDR : cls == C_LI ? M2R_IMM : M2R_ALU;
    busy = state != S_IDLE;
    illegal = state == S_DECODE && !legal;
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table vectors, randomized reference-model run and start/reset corner sequences
module tb_multicycle_control;
  localparam int CW = 5;
  localparam logic [5:0] NOOP = 6'b000000, MOV = 6'b010000, ADD = 6'b010010, SUB = 6'b010011;
  localparam logic [5:0] ORR = 6'b010100, ANDR = 6'b010101, ADDI = 6'b110010, SUBI = 6'b110011;
  localparam logic [5:0] ORI = 6'b110100, ANDI = 6'b110101, BEQ = 6'b100000, LI = 6'b111001;
  localparam logic [5:0] LWI = 6'b111011, SWI = 6'b111100, BAD = 6'b111111;
  typedef struct packed {
    logic ir, opw, pcw, pcs;
    logic [1:0] sa, sb;
    logic [2:0] aop;
    logic mr, mw, rw;
    logic [1:0] m2r;
    logic busy, ill;
  } outs_t;
  typedef struct {
    logic st;
    logic [5:0] op;
    logic z;
    outs_t o;
    logic [CW-1:0] cnt;
  } vec_t;
  logic clk = 0, rst = 0, start = 0, zero = 0;
  logic [5:0] opcode = 0;
  logic ir_write, pc_write, pc_src, old_pc_write, mem_read, mem_write, reg_write, busy, illegal;
  logic [1:0] alu_src_a, alu_src_b, mem_to_reg;
  logic [2:0] alu_op;
  logic [CW-1:0] instr_count;
  outs_t got;
  int vecs = 0, miss = 0;
  logic [CW-1:0] mc;
  outs_t exp_q[$];
  vec_t vt[$];
  logic [5:0] ops [14] = '{NOOP, MOV, ADD, SUB, ORR, ANDR, ADDI, SUBI, ORI, ANDI, BEQ, LI, LWI, SWI};
  always #5 clk = ~clk;
  multicycle_control #(.CNT_W(CW), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .old_pc_write(old_pc_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .busy(busy), .illegal(illegal), .instr_count(instr_count)
  );
  assign got = {ir_write, old_pc_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
                mem_read, mem_write, reg_write, mem_to_reg, busy, illegal};
  function automatic outs_t mk(input logic ir, opw, pcw, pcs, input logic [1:0] sa, sb,
                               input logic [2:0] aop, input logic mr, mw, rw,
                               input logic [1:0] m2r, input logic ill);
    return {ir, opw, pcw, pcs, sa, sb, aop, mr, mw, rw, m2r, 1'b1, ill};
  endfunction
  task automatic chk(input outs_t e, input logic [CW-1:0] ec, input string nm);
    @(negedge clk);
    vecs++;
    if (got !== e || instr_count !== ec) begin
      miss++;
      $display("FAIL %s: got outs=%b count=%0d, expected outs=%b count=%0d", nm, got, instr_count, e, ec);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic addv(input logic st, input logic [5:0] op, input logic z, input outs_t o, input logic [CW-1:0] c);
    vt.push_back('{st, op, z, o, c});
  endtask
  // Reference: the cycle-by-cycle control word sequence each instruction kind must produce.
  task automatic build(input logic [5:0] op, input logic z);
    logic [2:0] aop;
    logic [1:0] isb;
    int kind;
    aop = 0;
    isb = 2;
    case (op)
      NOOP: kind = 0;
      MOV: begin kind = 1; aop = 4; end
      ADD: kind = 1;
      SUB: begin kind = 1; aop = 1; end
      ORR: begin kind = 1; aop = 2; end
      ANDR: begin kind = 1; aop = 3; end
      ADDI: kind = 2;
      SUBI: begin kind = 2; aop = 1; end
      ORI: begin kind = 2; aop = 2; isb = 3; end
      ANDI: begin kind = 2; aop = 3; isb = 3; end
      BEQ: kind = 3;
      LWI: kind = 4;
      SWI: kind = 5;
      LI: kind = 6;
      default: kind = 7;
    endcase
    exp_q.delete();
    exp_q.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, kind == 7));
    if (kind == 1) exp_q.push_back(mk(0, 0, 0, 0, 1, 0, aop, 0, 0, 0, 0, 0));
    if (kind == 2) exp_q.push_back(mk(0, 0, 0, 0, 1, isb, aop, 0, 0, 0, 0, 0));
    if (kind == 3) exp_q.push_back(mk(0, 0, z, z, 1, 0, 1, 0, 0, 0, 0, 0));
    if (kind == 4) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    if (kind == 5) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    if (kind == 1 || kind == 2) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    if (kind == 4) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    if (kind == 6) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0));
  endtask
  initial begin
    outs_t f, d, di, wb;
    f = mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    d = mk(0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0);
    di = mk(0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 1);
    wb = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    addv(1, ADDI, 0, '0, 0);
    addv(1, ADDI, 0, f, 0); addv(1, ADDI, 0, d, 0);
    addv(1, ADDI, 0, mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0), 0); addv(1, ADDI, 0, wb, 0);
    addv(1, ORI, 0, f, 1); addv(1, ORI, 0, d, 1);
    addv(1, ORI, 0, mk(0, 0, 0, 0, 1, 3, 2, 0, 0, 0, 0, 0), 1); addv(1, ORI, 0, wb, 1);
    addv(1, MOV, 0, f, 2); addv(1, MOV, 0, d, 2);
    addv(1, MOV, 0, mk(0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0, 0), 2); addv(1, MOV, 0, wb, 2);
    addv(1, BEQ, 1, f, 3); addv(1, BEQ, 1, d, 3);
    addv(1, BEQ, 1, mk(0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0), 3);
    addv(1, BEQ, 0, f, 4); addv(1, BEQ, 0, d, 4);
    addv(1, BEQ, 0, mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), 4);
    addv(1, LWI, 0, f, 5); addv(1, LWI, 0, d, 5);
    addv(1, LWI, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 5);
    addv(1, LWI, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 5);
    addv(1, SWI, 0, f, 6); addv(1, SWI, 0, d, 6);
    addv(1, SWI, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 6);
    addv(1, LI, 0, f, 7); addv(1, LI, 0, d, 7);
    addv(1, LI, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0), 7);
    addv(1, BAD, 0, f, 8); addv(1, BAD, 0, di, 8);
    repeat (3) tick;
    chk('0, 0, "rst_hold");
    tick;
    rst = 1;
    chk('0, 0, "reset_idle");
    tick;
    foreach (vt[i]) begin
      start = vt[i].st;
      opcode = vt[i].op;
      zero = vt[i].z;
      chk(vt[i].o, vt[i].cnt, $sformatf("tbl%0d", i));
      tick;
    end
    mc = 9;
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      logic z;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
      z = 1'($urandom_range(0, 1));
      build(op, z);
      start = n != 149;
      opcode = op;
      zero = z;
      foreach (exp_q[k]) begin
        chk(exp_q[k], mc, $sformatf("rand%0d_op%b_c%0d", n, op, k));
        tick;
      end
      mc++;
    end
    chk('0, mc, "stop_idle");
    tick;
    start = 1;
    opcode = ADD;
    chk('0, mc, "idle_go");
    tick;
    chk(f, mc, "drop_fetch");
    tick;
    chk(d, mc, "drop_decode");
    tick;
    start = 0;
    chk(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), mc, "drop_exec");
    tick;
    chk(wb, mc, "drop_wb");
    tick;
    mc++;
    chk('0, mc, "busy_fall");
    tick;
    start = 1;
    opcode = SWI;
    chk('0, mc, "swi_go");
    tick;
    chk(f, mc, "swi_fetch");
    tick;
    chk(d, mc, "swi_decode");
    tick;
    chk(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), mc, "swi_mem");
    rst = 0;
    tick;
    chk('0, 0, "rst_mid");
    tick;
    rst = 1;
    start = 0;
    chk('0, 0, "rst_after");
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Sequencing controller for the multicycle datapath. It waits for start, then steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It drives every datapath enable and mux select from the current state and the IR opcode. It sits beside the datapath, replaces the hard-wired control, and receives the IR opcode and the ALU zero flag back.

Parameters:
CNT_W, 16, width of retired-instruction counter
OP_W, 6, opcode width (IR[31:26])

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous, active-low
start  in  1  level; 1 = run program, 0 = stop at next instruction boundary
opcode  in  OP_W  IR[31:26]; valid from DECODE onward
zero  in  1  ALU zero flag (A-B==0) during BRANCH
ir_write  out  1  load IR from instruction memory at PC
pc_write  out  1  load PC from pc_src mux
pc_src  out  1  0=ALU result (PC+1), 1=ALUOut register (branch target)
old_pc_write  out  1  capture PC of current instruction
alu_src_a  out  2  0=PC, 1=A, 2=OldPC
alu_src_b  out  2  0=B, 1=const 1, 2=sign-ext imm16, 3=zero-ext imm16
alu_op  out  3  0=ADD, 1=SUB, 2=OR, 3=AND, 4=PASS_A
mem_read  out  1  data-memory read, address = zero-ext imm16
mem_write  out  1  data-memory write of register rd field (SWI)
reg_write  out  1  register-file write to IR[25:21]
mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=sign-ext imm16
busy  out  1  1 in any state other than IDLE
illegal  out  1  one-cycle pulse in DECODE on an unknown opcode
instr_count  out  CNT_W  instructions retired since reset

Behaviour:
- Reset (rst==0 at a clk edge) forces state IDLE and instr_count=0, regardless of the current state. This includes reset mid-instruction: no partial write completes after that edge.
- Outputs are Moore/decode combinational from the registered state and opcode. In IDLE every control output is 0, busy=0, illegal=0.
- Opcodes: NOOP 000000; R-type MOV 010000, ADD 010010, SUB 010011, OR 010100, AND 010101; I-type ADDI 110010, SUBI 110011, ORI 110100, ANDI 110101; BEQ 100000; LI 111001; LWI 111011; SWI 111100.
- IDLE: if start -> FETCH, else stay.
- FETCH: ir_write=1, old_pc_write=1, alu_src_a=0, alu_src_b=1, ADD, pc_write=1, pc_src=0. Next state is DECODE.
- DECODE: alu_src_a=2, alu_src_b=2, ADD (branch target = OldPC + sext(imm), latched in ALUOut). Next state by opcode:
  - NOOP or illegal: FETCH (illegal pulses for 1 cycle).
  - R/I ALU ops: EXEC.
  - BEQ: BRANCH.
  - LWI/SWI: MEM.
  - LI: WB.
- EXEC: R-type uses alu_src_a=1, alu_src_b=0. I-type uses alu_src_a=1 and alu_src_b=2 for ADDI/SUBI, 3 for ORI/ANDI. alu_op comes from the opcode low bits; MOV uses PASS_A. Next state is WB.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB. If zero: pc_write=1, pc_src=1. Next state is FETCH.
- MEM: LWI sets mem_read=1 and goes to WB. SWI sets mem_write=1 and goes to FETCH.
- WB: reg_write=1. mem_to_reg is 0 for ALU ops, 1 for LWI, 2 for LI. Next state is FETCH.
- Cycles per instruction: NOOP 2; BEQ, SWI and LI 3; ALU ops and LWI 4.
- instr_count increments by 1 on the cycle that leaves the final state of each instruction, including NOOP and illegal opcodes. It wraps modulo 2^CNT_W.
- start is sampled only where the next state would be FETCH, and in IDLE. If start==0 there, go to IDLE instead. An instruction in flight always completes.
- start and a completing instruction in the same cycle: the completion is counted first, then start is evaluated.

Decomposition:
- Shared package multicycle_pkg holds:
  - opcode constants
  - state encoding (IDLE, FETCH, DECODE, EXEC, BRANCH, MEM, WB)
  - alu_op codes
  - alu_src_a, alu_src_b and mem_to_reg select codes
- One combinational sub-module, multicycle_opdecode, maps opcode to {class, alu_op, imm_zext, legal}. The FSM in multicycle_control consumes it.

Test Plan:
- rst=0 for 3 cycles, then rst=1 with start=0 -> state IDLE, all outputs 0, busy=0, instr_count=0.
- start=1 with ADDI (110010) -> FETCH, DECODE, EXEC (alu_src_b=2, ADD), WB (reg_write=1, mem_to_reg=0); instr_count=1 after 4 cycles.
- ORI (110100) -> alu_src_b=3; MOV (010000) -> alu_op=PASS_A, alu_src_a=1.
- BEQ with zero=1 -> BRANCH cycle has pc_write=1, pc_src=1. With zero=0 -> pc_write=0. Each takes 3 cycles.
- Sequence LWI, SWI, LI, opcode 111111:
  - LWI: mem_read, then WB with mem_to_reg=1.
  - SWI: mem_write, then FETCH.
  - LI: WB with mem_to_reg=2.
  - 111111: illegal=1 for 1 cycle, then FETCH.
  - instr_count=4.
- Drop start during EXEC -> WB completes, then IDLE; busy falls. rst=0 during MEM of SWI -> mem_write=0 on the next cycle, state IDLE, instr_count=0.
